sum_tx_sequencer: RTL and testbench

- Controller that owns the UART transmitter on behalf of the latch/adder datapath.
- On a start request it snapshots the two latched 4-bit operands and their 5-bit sum, formats them as an ASCII line "AA+BB=SS" plus an optional CR LF, and feeds the line to the UART one byte at a time.
- It sits between the adder output and the uart_tx enable/data inputs, replacing direct manual driving of uart_tx_en.

---
 rtl/sum_tx_sequencer.sv | 179 +++++++++++++++++
 tb/tb_sum_tx_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/sum_tx_sequencer.sv
// sum_tx_sequencer
// Owns the UART transmitter for the latch/adder datapath. A start request
// snapshots op_a, op_b and sum. The sequencer then formats the line
// "AA+BB=SS" (optionally followed by CR LF) as decimal ASCII and hands it to
// uart_tx one byte at a time.
//
// UART handshake: tx_en is a single-cycle strobe. It is issued only when
// tx_busy is low, and tx_data is valid in that same cycle. The UART accepts
// the byte by raising tx_busy; that rise must arrive within ACK_TIMEOUT
// cycles, otherwise the frame is aborted with an err pulse. tx_busy falling
// again means the byte is finished, and only then is the next byte offered.
// tx_data keeps its last value while tx_en is low.
module sum_tx_sequencer #(
  parameter int SEND_CRLF   = 1,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] op_a,
  input  logic [3:0] op_b,
  input  logic [4:0] sum,
  input  logic       tx_busy,
  output logic       tx_en,
  output logic [7:0] tx_data,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [2:0] dbg_state
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] LOAD    = 3'd1;
  localparam logic [2:0] SEND    = 3'd2;
  localparam logic [2:0] WAIT_HI = 3'd3;
  localparam logic [2:0] WAIT_LO = 3'd4;
  localparam logic [2:0] FINISH  = 3'd5;

  localparam logic [3:0] LAST_IDX    = (SEND_CRLF != 0) ? 4'd9 : 4'd7;
  localparam logic [7:0] TIMEOUT_LIM = 8'(ACK_TIMEOUT);

  logic [2:0] r_state;
  logic [3:0] r_a;
  logic [3:0] r_b;
  logic [4:0] r_s;
  logic [7:0] r_a_t, r_a_o, r_b_t, r_b_o, r_s_t, r_s_o;
  logic [3:0] r_idx;
  logic [7:0] r_tcnt;
  logic       r_tx_en;
  logic [7:0] r_tx_data;
  logic       r_busy;
  logic       r_done;
  logic       r_err;
  logic [7:0] w_cur_byte;

  // ASCII of the decimal tens digit (value is at most 31)
  function automatic logic [7:0] dec_tens(input logic [4:0] v);
    logic [4:0] t;
    t = v / 5'd10;
    return 8'h30 + {3'b000, t};
  endfunction

  // ASCII of the decimal ones digit
  function automatic logic [7:0] dec_ones(input logic [4:0] v);
    logic [4:0] o;
    o = v % 5'd10;
    return 8'h30 + {3'b000, o};
  endfunction

  // select the byte of the line addressed by the byte index
  always_comb begin
    w_cur_byte = 8'h00;
    case (r_idx)
      4'd0:    w_cur_byte = r_a_t;
      4'd1:    w_cur_byte = r_a_o;
      4'd2:    w_cur_byte = 8'h2B;
      4'd3:    w_cur_byte = r_b_t;
      4'd4:    w_cur_byte = r_b_o;
      4'd5:    w_cur_byte = 8'h3D;
      4'd6:    w_cur_byte = r_s_t;
      4'd7:    w_cur_byte = r_s_o;
      4'd8:    w_cur_byte = 8'h0D;
      4'd9:    w_cur_byte = 8'h0A;
      default: w_cur_byte = 8'h00;
    endcase
  end

  // sequencer FSM: capture, format, then feed bytes through the UART handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_a       <= 4'd0;
      r_b       <= 4'd0;
      r_s       <= 5'd0;
      r_a_t     <= 8'h00;
      r_a_o     <= 8'h00;
      r_b_t     <= 8'h00;
      r_b_o     <= 8'h00;
      r_s_t     <= 8'h00;
      r_s_o     <= 8'h00;
      r_idx     <= 4'd0;
      r_tcnt    <= 8'd0;
      r_tx_en   <= 1'b0;
      r_tx_data <= 8'h00;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_tx_en <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= op_a;
            r_b     <= op_b;
            r_s     <= sum;
            r_busy  <= 1'b1;
            r_state <= LOAD;
          end
        end
        LOAD: begin
          r_a_t   <= dec_tens({1'b0, r_a});
          r_a_o   <= dec_ones({1'b0, r_a});
          r_b_t   <= dec_tens({1'b0, r_b});
          r_b_o   <= dec_ones({1'b0, r_b});
          r_s_t   <= dec_tens(r_s);
          r_s_o   <= dec_ones(r_s);
          r_idx   <= 4'd0;
          r_state <= SEND;
        end
        SEND: begin
          if (!tx_busy) begin
            r_tx_en   <= 1'b1;
            r_tx_data <= w_cur_byte;
            r_tcnt    <= 8'd0;
            r_state   <= WAIT_HI;
          end
        end
        WAIT_HI: begin
          if (tx_busy) begin
            r_state <= WAIT_LO;
          end else begin
            r_tcnt <= r_tcnt + 8'd1;
            if (r_tcnt + 8'd1 == TIMEOUT_LIM) begin
              r_err   <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end
          end
        end
        WAIT_LO: begin
          if (!tx_busy) begin
            if (r_idx == LAST_IDX) begin
              r_state <= FINISH;
            end else begin
              r_idx   <= r_idx + 4'd1;
              r_state <= SEND;
            end
          end
        end
        FINISH: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign tx_en     = r_tx_en;
  assign tx_data   = r_tx_data;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_sum_tx_sequencer.sv
// Bench for sum_tx_sequencer: u0 sends CR LF, u1 does not. Each instance has
// its own UART model. Expected bytes and done/err events are queued when
// stimulus is issued, and a monitor pops them as the DUT produces them.
module tb_sum_tx_sequencer;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic [1:0] start_w;
  logic [3:0] op_a_w [2];
  logic [3:0] op_b_w [2];
  logic [4:0] sum_w  [2];
  logic [1:0] tx_busy_w = 2'b00;
  logic [1:0] tx_en_w, busy_w, done_w, err_w;
  logic [7:0] tx_data_w [2];
  logic [2:0] st_w [2];
  logic [1:0] uart_dead;
  int         ucnt [2] = '{0, 0};

  int n_checks = 0, n_fail = 0;
  int mon_checks = 0, mon_fail = 0;
  int n_tx [2] = '{0, 0};

  // {kind, byte}: kind 0 = byte on tx_en, 1 = done pulse, 2 = err pulse
  logic [9:0] exp_q0[$];
  logic [9:0] exp_q1[$];

  logic [7:0] fr_a [10] = '{8'h30, 8'h33, 8'h2B, 8'h30, 8'h39, 8'h3D, 8'h31, 8'h32, 8'h0D, 8'h0A};
  logic [7:0] fr_b [8]  = '{8'h31, 8'h35, 8'h2B, 8'h31, 8'h35, 8'h3D, 8'h33, 8'h30};

  sum_tx_sequencer #(.SEND_CRLF(1), .ACK_TIMEOUT(64)) u0 (
    .clk(clk), .reset(reset), .start(start_w[0]), .op_a(op_a_w[0]), .op_b(op_b_w[0]),
    .sum(sum_w[0]), .tx_busy(tx_busy_w[0]), .tx_en(tx_en_w[0]), .tx_data(tx_data_w[0]),
    .busy(busy_w[0]), .done(done_w[0]), .err(err_w[0]), .dbg_state(st_w[0]));

  sum_tx_sequencer #(.SEND_CRLF(0), .ACK_TIMEOUT(64)) u1 (
    .clk(clk), .reset(reset), .start(start_w[1]), .op_a(op_a_w[1]), .op_b(op_b_w[1]),
    .sum(sum_w[1]), .tx_busy(tx_busy_w[1]), .tx_en(tx_en_w[1]), .tx_data(tx_data_w[1]),
    .busy(busy_w[1]), .done(done_w[1]), .err(err_w[1]), .dbg_state(st_w[1]));

  // UART model: busy for 10 cycles after each accepted strobe, or never if dead
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (ucnt[i] != 0) begin
        ucnt[i] <= ucnt[i] - 1;
        if (ucnt[i] == 1) tx_busy_w[i] <= 1'b0;
      end else if (tx_en_w[i] && !uart_dead[i]) begin
        tx_busy_w[i] <= 1'b1;
        ucnt[i]      <= 10;
      end
    end
  end

  task automatic mon_obs(input int i, input logic [9:0] obs);
    logic [9:0] e;
    mon_checks++;
    if ((i == 0 && exp_q0.size() == 0) || (i == 1 && exp_q1.size() == 0)) begin
      mon_fail++;
      $display("FAIL u%0d_unexpected_event: got %03h, expected nothing", i, obs);
    end else begin
      e = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
      if (obs !== e) begin
        mon_fail++;
        $display("FAIL u%0d_event: got %03h expected %03h", i, obs, e);
      end
    end
  endtask

  // monitor: sample away from the active edge and score every DUT event
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (tx_en_w[i] === 1'b1) begin
        n_tx[i]++;
        mon_obs(i, {2'd0, tx_data_w[i]});
        mon_checks++;
        if (tx_busy_w[i] !== 1'b0) begin
          mon_fail++;
          $display("FAIL u%0d_tx_en_while_busy: tx_busy=%0b expected 0", i, tx_busy_w[i]);
        end
      end
      if (done_w[i] === 1'b1) mon_obs(i, {2'd1, 8'h00});
      if (err_w[i] === 1'b1)  mon_obs(i, {2'd2, 8'h00});
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse_start(input int i);
    @(posedge clk); #1 start_w[i] = 1'b1;
    @(posedge clk); #1 start_w[i] = 1'b0;
  endtask

  task automatic set_ops(input int i, input logic [3:0] a, input logic [3:0] b, input logic [4:0] s);
    op_a_w[i] = a; op_b_w[i] = b; sum_w[i] = s;
  endtask

  // wait for done on instance i, counting cycles where busy dropped early
  task automatic wait_done(input int i, output int got, output int bad);
    got = 0; bad = 0;
    for (int k = 0; k < 2000 && got == 0; k++) begin
      @(negedge clk);
      if (done_w[i]) got = 1;
      else if (!busy_w[i]) bad++;
    end
  endtask

  initial begin
    int got, bad, n, base, t0;
    start_w = 2'b00; uart_dead = 2'b00;
    set_ops(0, 4'd0, 4'd0, 5'd0);
    set_ops(1, 4'd0, 4'd0, 5'd0);

    // reset held 3 cycles
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_tx_en", {30'd0, tx_en_w}, 0);
    chk("rst_busy",  {30'd0, busy_w}, 0);
    chk("rst_done",  {30'd0, done_w}, 0);
    chk("rst_err",   {30'd0, err_w}, 0);
    chk("rst_tx_data", {16'd0, tx_data_w[0], tx_data_w[1]}, 0);
    chk("rst_state", {26'd0, st_w[0], st_w[1]}, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    t0 = n_tx[0] + n_tx[1];
    repeat (20) @(posedge clk);
    #1 chk("idle_no_tx_en", n_tx[0] + n_tx[1] - t0, 0);

    // 3 + 9 = 12 with CR LF; second start mid-frame is ignored
    set_ops(0, 4'd3, 4'd9, 5'd12);
    foreach (fr_a[j]) exp_q0.push_back({2'd0, fr_a[j]});
    exp_q0.push_back({2'd1, 8'h00});
    @(posedge clk); #1 start_w[0] = 1'b1;
    @(posedge clk); #1 start_w[0] = 1'b0;
    chk("busy_on_accept", busy_w[0], 1);
    chk("no_tx_en_in_load", tx_en_w[0], 0);
    @(posedge clk); #1 chk("tx_en_before_latency", tx_en_w[0], 0);
    @(posedge clk); #1 chk("first_tx_latency", tx_en_w[0], 1);
    got = 0; bad = 0;
    for (int k = 0; k < 2000 && got == 0; k++) begin
      @(negedge clk);
      start_w[0] = (k == 40);
      if (done_w[0]) got = 1;
      else if (!busy_w[0]) bad++;
    end
    start_w[0] = 1'b0;
    chk("crlf_done_seen", got, 1);
    chk("crlf_busy_span", bad, 0);
    chk("busy_clear_at_done", busy_w[0], 0);
    repeat (40) @(negedge clk);
    chk("crlf_queue_drained", exp_q0.size(), 0);
    chk("crlf_tx_count", n_tx[0], 10);

    // 15 + 15 = 30 without CR LF; operands change mid-frame
    set_ops(1, 4'd15, 4'd15, 5'd30);
    foreach (fr_b[j]) exp_q1.push_back({2'd0, fr_b[j]});
    exp_q1.push_back({2'd1, 8'h00});
    pulse_start(1);
    got = 0; bad = 0;
    for (int k = 0; k < 2000 && got == 0; k++) begin
      @(negedge clk);
      if (k == 20) set_ops(1, 4'd0, 4'd1, 5'd1);
      if (done_w[1]) got = 1;
      else if (!busy_w[1]) bad++;
    end
    chk("nocrlf_done_seen", got, 1);
    chk("nocrlf_busy_span", bad, 0);
    repeat (30) @(negedge clk);
    chk("nocrlf_tx_count", n_tx[1], 8);
    chk("nocrlf_queue_drained", exp_q1.size(), 0);

    // UART never acknowledges: err after ACK_TIMEOUT cycles
    uart_dead[0] = 1'b1;
    set_ops(0, 4'd1, 4'd2, 5'd3);
    exp_q0.push_back({2'd0, 8'h30});
    exp_q0.push_back({2'd2, 8'h00});
    pulse_start(0);
    got = 0;
    for (int k = 0; k < 20 && got == 0; k++) begin
      @(negedge clk);
      if (tx_en_w[0]) got = 1;
    end
    chk("timeout_tx_en_seen", got, 1);
    n = 0;
    while (n < 200 && !err_w[0]) begin
      @(negedge clk);
      n++;
    end
    chk("err_latency", n, 64);
    chk("busy_clear_at_err", busy_w[0], 0);
    repeat (20) @(negedge clk);
    chk("timeout_queue_drained", exp_q0.size(), 0);
    uart_dead[0] = 1'b0;

    // reset during WAIT_LO of byte index 4, then a fresh frame
    set_ops(0, 4'd3, 4'd9, 5'd12);
    for (int j = 0; j < 5; j++) exp_q0.push_back({2'd0, fr_a[j]});
    base = n_tx[0];
    pulse_start(0);
    got = 0;
    for (int k = 0; k < 2000 && got == 0; k++) begin
      @(negedge clk);
      if (n_tx[0] - base == 5 && st_w[0] == 3'd4) got = 1;
    end
    chk("reached_wait_lo_byte4", got, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midframe_rst_busy", busy_w[0], 0);
    chk("midframe_rst_tx_en", tx_en_w[0], 0);
    chk("midframe_rst_state", st_w[0], 0);
    reset = 1'b0;
    chk("midframe_queue_drained", exp_q0.size(), 0);
    foreach (fr_a[j]) exp_q0.push_back({2'd0, fr_a[j]});
    exp_q0.push_back({2'd1, 8'h00});
    pulse_start(0);
    wait_done(0, got, bad);
    chk("fresh_done_seen", got, 1);
    chk("fresh_busy_span", bad, 0);
    repeat (30) @(negedge clk);
    chk("fresh_queue_drained", exp_q0.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks + mon_checks, n_fail + mon_fail);
    $finish;
  end

endmodule
